// File: rtl/zcache_pkg.sv
// Shared definitions for the zcache word cache: FSM states, entry field widths
// and the byte-merge helper used for write-through updates.
package zcache_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam int VALID_W = 1;
  localparam int DATA_W  = 16;
  localparam int BYTE_W  = 8;

  // Replace one byte of a cached word; bsel=1 picks the upper byte.
  function automatic logic [DATA_W-1:0] merge_byte(
    input logic [DATA_W-1:0] word,
    input logic              bsel,
    input logic [BYTE_W-1:0] wbyte
  );
    logic [DATA_W-1:0] res;
    res = word;
    if (bsel) begin
      res[DATA_W-1:BYTE_W] = wbyte;
    end else begin
      res[BYTE_W-1:0] = wbyte;
    end
    return res;
  endfunction

endpackage

// File: rtl/zcache_if.sv
// CPU/DRAM-side bundle of the zcache: address, strobes, fill path and the
// hit/statistics results.
interface zcache_if
  import zcache_pkg::*;
#(
  parameter int INDEX_W = 8,
  parameter int TAG_W   = 14,
  parameter int CNT_W   = 16
);

  logic [TAG_W+INDEX_W-1:0] addr;
  logic                     rd_s;
  logic                     wr_s;
  logic                     wr_bsel;
  logic [BYTE_W-1:0]        wr_data;
  logic                     fill;
  logic [DATA_W-1:0]        fill_data;
  logic                     flush;
  logic                     hit;
  logic [DATA_W-1:0]        hit_data;
  logic                     busy;
  logic [CNT_W-1:0]         hit_cnt;
  logic [CNT_W-1:0]         miss_cnt;

  modport master (
    output addr, rd_s, wr_s, wr_bsel, wr_data, fill, fill_data, flush,
    input  hit, hit_data, busy, hit_cnt, miss_cnt
  );

  modport slave (
    input  addr, rd_s, wr_s, wr_bsel, wr_data, fill, fill_data, flush,
    output hit, hit_data, busy, hit_cnt, miss_cnt
  );

endinterface

// File: rtl/zcache_way.sv
// One cache way: synchronous-read {valid, tag, data} RAM with write-first
// forwarding, followed by the tag comparator for the registered address.
module zcache_way
  import zcache_pkg::*;
#(
  parameter int INDEX_W = 8,
  parameter int TAG_W   = 14
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INDEX_W-1:0] ridx,
  input  logic [INDEX_W-1:0] widx,
  input  logic               we,
  input  logic               wvalid,
  input  logic [TAG_W-1:0]   wtag,
  input  logic [DATA_W-1:0]  wdata,
  input  logic [TAG_W-1:0]   cmp_tag,
  output logic               valid,
  output logic               match,
  output logic [DATA_W-1:0]  data
);

  localparam int DEPTH   = 1 << INDEX_W;
  localparam int ENTRY_W = VALID_W + TAG_W + DATA_W;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ENTRY_W-1:0] went;
  logic [ENTRY_W-1:0] rd_r;

  assign went = {wvalid, wtag, wdata};

  // RAM write port; contents have no reset and are invalidated by flushing
  always_ff @(posedge clk) begin
    if (we) begin
      mem[widx] <= went;
    end
  end

  // Read register; a same-edge write to the read index is forwarded so a
  // fresh fill or byte update is visible on the very next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_r <= '0;
    end else if (we && (widx == ridx)) begin
      rd_r <= went;
    end else begin
      rd_r <= mem[ridx];
    end
  end

  assign valid = rd_r[ENTRY_W-1];
  assign match = valid & (rd_r[DATA_W +: TAG_W] == cmp_tag);
  assign data  = rd_r[DATA_W-1:0];

endmodule

// File: rtl/zcache.sv
// zcache top: WAYS-way word cache with LRU replacement, write-through byte
// updates, saturating hit/miss counters and a one-set-per-clock flush FSM.
module zcache
  import zcache_pkg::*;
#(
  parameter int INDEX_W = 8,
  parameter int TAG_W   = 14,
  parameter int WAYS    = 2,
  parameter int CNT_W   = 16
) (
  input logic     clk,
  input logic     rst_n,
  zcache_if.slave bus
);

  localparam int                 SETS     = 1 << INDEX_W;
  localparam logic [INDEX_W-1:0] LAST_IDX = {INDEX_W{1'b1}};

  state_t             state_r;
  state_t             state_next;
  logic [INDEX_W-1:0] cnt_r;
  logic [INDEX_W-1:0] cnt_next;
  logic [INDEX_W-1:0] idx_r;
  logic [TAG_W-1:0]   tag_r;
  logic [CNT_W-1:0]   hit_cnt_r;
  logic [CNT_W-1:0]   miss_cnt_r;

  logic               idle;
  logic               op_en;
  logic               op_fill;
  logic               op_wr;
  logic               op_rd;
  logic               hit_any;
  logic               hit_way;
  logic               victim;
  logic [DATA_W-1:0]  hit_word;
  logic [DATA_W-1:0]  wr_word;
  logic [INDEX_W-1:0] widx;
  logic [INDEX_W-1:0] ridx;

  logic [WAYS-1:0]    way_we;
  logic [WAYS-1:0]    way_valid;
  logic [WAYS-1:0]    way_match;
  logic [DATA_W-1:0]  way_data [WAYS];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  assign ridx = bus.addr[INDEX_W-1:0];
  assign idle = (state_r == IDLE);

  // A flush strobe takes priority over any access in the same cycle
  assign op_en   = idle & ~bus.flush;
  assign op_fill = op_en & bus.fill;
  assign op_wr   = op_en & bus.wr_s & hit_any & ~bus.fill;
  assign op_rd   = op_en & bus.rd_s;

  // FSM state and flush index register; reset enters FLUSH at index 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= FLUSH;
      cnt_r   <= '0;
    end else begin
      state_r <= state_next;
      cnt_r   <= cnt_next;
    end
  end

  // Next-state logic for the IDLE/FLUSH sequencer
  always_comb begin
    state_next = state_r;
    cnt_next   = cnt_r;
    case (state_r)
      IDLE: begin
        if (bus.flush) begin
          state_next = FLUSH;
          cnt_next   = '0;
        end else begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      end
      FLUSH: begin
        if (bus.flush) begin
          state_next = FLUSH;
          cnt_next   = '0;
        end else if (cnt_r == LAST_IDX) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          state_next = FLUSH;
          cnt_next   = cnt_r + INDEX_W'(1);
        end
      end
      default: begin
        state_next = FLUSH;
        cnt_next   = '0;
      end
    endcase
  end

  // Address register: the ways compare against the previous edge's address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r <= '0;
      tag_r <= '0;
    end else begin
      idx_r <= bus.addr[INDEX_W-1:0];
      tag_r <= bus.addr[INDEX_W +: TAG_W];
    end
  end

  // Word to store: fill data or hit data, with the write byte merged in
  always_comb begin
    wr_word = hit_word;
    if (bus.fill) begin
      if (bus.wr_s) begin
        wr_word = merge_byte(bus.fill_data, bus.wr_bsel, bus.wr_data);
      end else begin
        wr_word = bus.fill_data;
      end
    end else begin
      wr_word = merge_byte(hit_word, bus.wr_bsel, bus.wr_data);
    end
  end

  assign widx = idle ? idx_r : cnt_r;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign way_we[w] = ~idle
                     | (op_fill & (victim == 1'(w)))
                     | (op_wr & (hit_way == 1'(w)));

    zcache_way #(
      .INDEX_W (INDEX_W),
      .TAG_W   (TAG_W)
    ) u_way (
      .clk     (clk),
      .rst_n   (rst_n),
      .ridx    (ridx),
      .widx    (widx),
      .we      (way_we[w]),
      .wvalid  (idle),
      .wtag    (tag_r),
      .wdata   (wr_word),
      .cmp_tag (tag_r),
      .valid   (way_valid[w]),
      .match   (way_match[w]),
      .data    (way_data[w])
    );
  end

  assign hit_any = |way_match;

  if (WAYS == 2) begin : g_lru
    // LRU bit names the way to evict next
    logic lru_mem [SETS];
    logic lru_q;
    logic lru_we;
    logic lru_wbit;

    assign hit_way  = way_match[1];
    assign hit_word = hit_way ? way_data[1] : way_data[0];
    assign victim   = ~way_valid[0] ? 1'b0 : (~way_valid[1] ? 1'b1 : lru_q);
    assign lru_we   = op_fill | (op_rd & hit_any);
    assign lru_wbit = op_fill ? ~victim : ~hit_way;

    // LRU RAM write port
    always_ff @(posedge clk) begin
      if (lru_we) begin
        lru_mem[idx_r] <= lru_wbit;
      end
    end

    // LRU read register with same-edge write forwarding
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lru_q <= 1'b0;
      end else if (lru_we && (idx_r == ridx)) begin
        lru_q <= lru_wbit;
      end else begin
        lru_q <= lru_mem[ridx];
      end
    end
  end else begin : g_direct
    assign hit_way  = 1'b0;
    assign victim   = 1'b0;
    assign hit_word = way_data[0];
  end

  // Saturating statistics; any flush strobe clears them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_r  <= '0;
      miss_cnt_r <= '0;
    end else if (bus.flush) begin
      hit_cnt_r  <= '0;
      miss_cnt_r <= '0;
    end else if (op_rd) begin
      if (hit_any) begin
        hit_cnt_r <= sat_inc(hit_cnt_r);
      end else begin
        miss_cnt_r <= sat_inc(miss_cnt_r);
      end
    end else begin
      hit_cnt_r  <= hit_cnt_r;
      miss_cnt_r <= miss_cnt_r;
    end
  end

  assign bus.hit      = idle & hit_any;
  assign bus.hit_data = hit_word;
  assign bus.busy     = ~idle;
  assign bus.hit_cnt  = hit_cnt_r;
  assign bus.miss_cnt = miss_cnt_r;

endmodule

// File: tb/tb_zcache.sv
// Directed self-checking bench for zcache (INDEX_W=8, TAG_W=14, WAYS=2, CNT_W=16).
module tb_zcache;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  localparam logic [21:0] ADDR_A = 22'h012345;
  localparam logic [21:0] ADDR_B = 22'h0ABC45;
  localparam logic [21:0] ADDR_C = 22'h1F0045;
  localparam logic [21:0] ADDR_D = 22'h2AAA45;
  localparam logic [21:0] ADDR_E = 22'h000310;

  zcache_if #(.INDEX_W(8), .TAG_W(14), .CNT_W(16)) bus ();

  zcache #(.INDEX_W(8), .TAG_W(14), .WAYS(2), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_addr(input logic [21:0] a);
    bus.addr = a;
    tick(1);
  endtask

  task automatic do_fill(input logic [15:0] d);
    bus.fill      = 1'b1;
    bus.fill_data = d;
    tick(1);
    bus.fill      = 1'b0;
  endtask

  task automatic do_rd();
    bus.rd_s = 1'b1;
    tick(1);
    bus.rd_s = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    tick(2);
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL rst_busy got=%b exp=1", bus.busy); end
    checks++; if (bus.hit !== 1'b0) begin failures++; $display("FAIL rst_hit got=%b exp=0", bus.hit); end
    checks++; if (bus.hit_cnt !== 16'h0000) begin failures++; $display("FAIL rst_hit_cnt got=%h exp=0000", bus.hit_cnt); end
    checks++; if (bus.miss_cnt !== 16'h0000) begin failures++; $display("FAIL rst_miss_cnt got=%h exp=0000", bus.miss_cnt); end
    rst_n = 1'b1;
    tick(255);
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL init_busy_255 got=%b exp=1", bus.busy); end
    tick(1);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL init_busy_256 got=%b exp=0", bus.busy); end
    checks++; if (bus.hit !== 1'b0) begin failures++; $display("FAIL init_hit got=%b exp=0", bus.hit); end
  endtask

  task automatic test_fill_read();
    do_fill(16'hBEEF);
    checks++; if (bus.hit !== 1'b1) begin failures++; $display("FAIL fill_hit got=%b exp=1", bus.hit); end
    checks++; if (bus.hit_data !== 16'hBEEF) begin failures++; $display("FAIL fill_data got=%h exp=beef", bus.hit_data); end
    do_rd();
    checks++; if (bus.hit_cnt !== 16'd1) begin failures++; $display("FAIL rd_hit_cnt got=%h exp=0001", bus.hit_cnt); end
    checks++; if (bus.miss_cnt !== 16'd0) begin failures++; $display("FAIL rd_miss_cnt got=%h exp=0000", bus.miss_cnt); end
  endtask

  task automatic test_lru();
    set_addr(ADDR_B);
    checks++; if (bus.hit !== 1'b0) begin failures++; $display("FAIL lru_b_cold got=%b exp=0", bus.hit); end
    do_rd();
    checks++; if (bus.miss_cnt !== 16'd1) begin failures++; $display("FAIL lru_miss1 got=%h exp=0001", bus.miss_cnt); end
    do_fill(16'h1111);
    checks++; if (bus.hit_data !== 16'h1111 || bus.hit !== 1'b1) begin failures++; $display("FAIL lru_b_fill got=%b/%h exp=1/1111", bus.hit, bus.hit_data); end
    set_addr(ADDR_A);
    checks++; if (bus.hit_data !== 16'hBEEF || bus.hit !== 1'b1) begin failures++; $display("FAIL lru_a_keep got=%b/%h exp=1/beef", bus.hit, bus.hit_data); end
    do_rd();
    checks++; if (bus.hit_cnt !== 16'd2) begin failures++; $display("FAIL lru_hit2 got=%h exp=0002", bus.hit_cnt); end
    set_addr(ADDR_C);
    checks++; if (bus.hit !== 1'b0) begin failures++; $display("FAIL lru_c_cold got=%b exp=0", bus.hit); end
    do_fill(16'h2222);
    checks++; if (bus.hit_data !== 16'h2222 || bus.hit !== 1'b1) begin failures++; $display("FAIL lru_c_fill got=%b/%h exp=1/2222", bus.hit, bus.hit_data); end
    set_addr(ADDR_A);
    checks++; if (bus.hit_data !== 16'hBEEF || bus.hit !== 1'b1) begin failures++; $display("FAIL lru_a_survives got=%b/%h exp=1/beef", bus.hit, bus.hit_data); end
    set_addr(ADDR_B);
    checks++; if (bus.hit !== 1'b0) begin failures++; $display("FAIL lru_b_evicted got=%b exp=0", bus.hit); end
    do_rd();
    checks++; if (bus.miss_cnt !== 16'd2) begin failures++; $display("FAIL lru_miss2 got=%h exp=0002", bus.miss_cnt); end
    checks++; if (bus.hit_cnt !== 16'd2) begin failures++; $display("FAIL lru_hit_hold got=%h exp=0002", bus.hit_cnt); end
  endtask

  task automatic test_write();
    set_addr(ADDR_A);
    bus.wr_s    = 1'b1;
    bus.wr_bsel = 1'b1;
    bus.wr_data = 8'h12;
    tick(1);
    bus.wr_s    = 1'b0;
    checks++; if (bus.hit_data !== 16'h12EF || bus.hit !== 1'b1) begin failures++; $display("FAIL wr_hi_byte got=%b/%h exp=1/12ef", bus.hit, bus.hit_data); end
    set_addr(ADDR_D);
    bus.wr_s    = 1'b1;
    bus.wr_bsel = 1'b0;
    bus.wr_data = 8'h77;
    tick(1);
    bus.wr_s    = 1'b0;
    checks++; if (bus.hit !== 1'b0) begin failures++; $display("FAIL wr_miss_alloc got=%b exp=0", bus.hit); end
    set_addr(ADDR_A);
    checks++; if (bus.hit_data !== 16'h12EF) begin failures++; $display("FAIL wr_a_after got=%h exp=12ef", bus.hit_data); end
    set_addr(ADDR_C);
    checks++; if (bus.hit_data !== 16'h2222 || bus.hit !== 1'b1) begin failures++; $display("FAIL wr_c_after got=%b/%h exp=1/2222", bus.hit, bus.hit_data); end
  endtask

  task automatic test_fill_merge();
    set_addr(ADDR_E);
    checks++; if (bus.hit !== 1'b0) begin failures++; $display("FAIL merge_cold got=%b exp=0", bus.hit); end
    bus.fill      = 1'b1;
    bus.fill_data = 16'h0000;
    bus.wr_s      = 1'b1;
    bus.wr_bsel   = 1'b0;
    bus.wr_data   = 8'h55;
    tick(1);
    bus.fill      = 1'b0;
    bus.wr_s      = 1'b0;
    checks++; if (bus.hit_data !== 16'h0055 || bus.hit !== 1'b1) begin failures++; $display("FAIL merge_word got=%b/%h exp=1/0055", bus.hit, bus.hit_data); end
  endtask

  task automatic test_flush();
    set_addr(ADDR_A);
    bus.rd_s = 1'b1;
    tick(65540);
    bus.rd_s = 1'b0;
    checks++; if (bus.hit_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_hit_cnt got=%h exp=ffff", bus.hit_cnt); end
    bus.flush = 1'b1;
    tick(1);
    bus.flush = 1'b0;
    checks++; if (bus.hit_cnt !== 16'h0000 || bus.miss_cnt !== 16'h0000) begin failures++; $display("FAIL flush_clear got=%h/%h exp=0000/0000", bus.hit_cnt, bus.miss_cnt); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL flush_busy got=%b exp=1", bus.busy); end
    checks++; if (bus.hit !== 1'b0) begin failures++; $display("FAIL flush_hit_forced got=%b exp=0", bus.hit); end
    do_rd();
    checks++; if (bus.miss_cnt !== 16'h0000 || bus.hit_cnt !== 16'h0000) begin failures++; $display("FAIL flush_rd_ignored got=%h/%h exp=0000/0000", bus.hit_cnt, bus.miss_cnt); end
    tick(98);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b1 || bus.hit !== 1'b0) begin failures++; $display("FAIL midflush_rst got=%b/%b exp=1/0", bus.busy, bus.hit); end
    #2;
    rst_n = 1'b1;
    tick(255);
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL reflush_busy_255 got=%b exp=1", bus.busy); end
    tick(1);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reflush_busy_256 got=%b exp=0", bus.busy); end
    checks++; if (bus.hit !== 1'b0) begin failures++; $display("FAIL post_flush_a got=%b exp=0", bus.hit); end
    do_rd();
    checks++; if (bus.miss_cnt !== 16'd1 || bus.hit_cnt !== 16'd0) begin failures++; $display("FAIL post_flush_cnt got=%h/%h exp=0000/0001", bus.hit_cnt, bus.miss_cnt); end
    set_addr(ADDR_C);
    checks++; if (bus.hit !== 1'b0) begin failures++; $display("FAIL post_flush_c got=%b exp=0", bus.hit); end
    set_addr(ADDR_E);
    checks++; if (bus.hit !== 1'b0) begin failures++; $display("FAIL post_flush_e got=%b exp=0", bus.hit); end
  endtask

  initial begin
    clk           = 1'b0;
    rst_n         = 1'b1;
    checks        = 0;
    failures      = 0;
    bus.addr      = ADDR_A;
    bus.rd_s      = 1'b0;
    bus.wr_s      = 1'b0;
    bus.wr_bsel   = 1'b0;
    bus.wr_data   = 8'h00;
    bus.fill      = 1'b0;
    bus.fill_data = 16'h0000;
    bus.flush     = 1'b0;
    test_reset();
    test_fill_read();
    test_lru();
    test_write();
    test_fill_merge();
    test_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/zcache.md
ZCACHE -- requirements
Module: zcache

Interface
REQ-001 The block SHALL have a parameter INDEX_W, default 8, giving the set index width (2^INDEX_W sets).
REQ-002 The block SHALL have a parameter TAG_W, default 14, giving the tag width: {rom_n_ram, page[7:0], za[13:9]}.
REQ-003 The block SHALL have a parameter WAYS, default 2, legal values 1 or 2, giving associativity.
REQ-004 The block SHALL have a parameter CNT_W, default 16, giving the width of each statistics counter.
REQ-005 clk  in  1  system clock; all state changes on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 addr  in  TAG_W+INDEX_W  word address {tag, index}; held stable by the CPU for the whole memory cycle.
REQ-008 rd_s  in  1  one-clk strobe per CPU read cycle, used for statistics and LRU update.
REQ-009 wr_s  in  1  one-clk strobe per CPU write cycle to a writable window.
REQ-010 wr_bsel  in  1  byte select for the write: 0 selects [7:0], 1 selects [15:8].
REQ-011 wr_data  in  8  write byte.
REQ-012 fill  in  1  one-clk strobe: the DRAM word for addr is valid on fill_data.
REQ-013 fill_data  in  16  DRAM read word.
REQ-014 flush  in  1  one-clk strobe requesting invalidation of the whole cache.
REQ-015 hit  out  1  addr is cached and valid.
REQ-016 hit_data  out  16  cached word for addr.
REQ-017 busy  out  1  flush in progress.
REQ-018 hit_cnt  out  CNT_W  count of read hits.
REQ-019 miss_cnt  out  CNT_W  count of read misses.

Function
REQ-020 Storage SHALL be WAYS banks of synchronous-read RAM; each entry is {valid, tag, data[15:0]}, plus one LRU bit per set when WAYS=2.
REQ-021 The read latency SHALL be 1 clk: hit and hit_data reflect the addr sampled on the previous rising edge.
REQ-022 hit SHALL be 1 only when some way holds valid=1 with a tag equal to addr's tag; hit_data SHALL be that way's data, and SHALL be don't-care when hit=0.
REQ-023 On rd_s with hit=1, the LRU bit of the set SHALL point to the way that was not hit.
REQ-024 On fill, the victim SHALL be chosen in this order: the first invalid way, lowest index first; otherwise the LRU way; WAYS=1 always uses way 0.
REQ-025 On fill, the victim SHALL be written with {1, tag, fill_data}, and the LRU bit SHALL be set to the other way.
REQ-026 On wr_s with hit=1, the selected byte of the hit way SHALL be updated (write-through update), and valid SHALL stay 1.
REQ-027 On wr_s with hit=0, there SHALL be no allocation and no state change.
REQ-028 When fill and wr_s occur in the same clk, the fill SHALL win, and wr_data SHALL be merged into the filled word at wr_bsel.
REQ-029 On rd_s, hit_cnt SHALL increment by 1 if hit=1, and miss_cnt SHALL increment by 1 otherwise.
REQ-030 Both counters SHALL saturate at all-ones, never wrap, and be cleared on flush start.
REQ-031 The FSM SHALL have exactly two states, IDLE and FLUSH.
REQ-032 IDLE SHALL transition to FLUSH on flush=1.
REQ-033 FLUSH SHALL clear valid on every way of index cnt, with cnt running 0..2^INDEX_W-1 at one set per clk.
REQ-034 FLUSH SHALL return to IDLE after the last index, so the flush takes 2^INDEX_W clks.
REQ-035 While in FLUSH: busy=1, hit is forced to 0, and fill, wr_s and rd_s are ignored (no counter change).
REQ-036 A flush strobe arriving during FLUSH SHALL restart cnt at 0.

Reset
REQ-037 Asserting rst_n=0 SHALL immediately set hit=0, hit_cnt=0, miss_cnt=0 and cnt=0, and force the FSM to FLUSH (busy=1).
REQ-038 After rst_n is released, the block SHALL complete a full flush (2^INDEX_W clks) before the first hit is possible, because RAM valid bits have no reset.
REQ-039 Reset asserted in the middle of a flush or fill SHALL abandon that operation, and the flush SHALL restart from index 0.

Structure
REQ-040 A shared package zcache_pkg SHALL hold the FSM state enumeration (IDLE, FLUSH) and the entry-field width constants.
REQ-041 The block SHALL contain one sub-module, zcache_way: a single way's tag/valid/data RAM plus tag comparator, instantiated WAYS times.
REQ-042 The LRU array SHALL be a separate 2^INDEX_W x 1 RAM; it SHALL be omitted when WAYS=1.

Verification
REQ-043 Release reset, wait 256 clks, present addr 0x012345 -> busy falls at clk 256, then hit=0.
REQ-044 Fill addr 0x012345 with 0xBEEF, then rd_s -> next clk hit=1, hit_data=0xBEEF, hit_cnt=1.
REQ-045 WAYS=2, index 0x45: fill tags A, then B; rd_s on A; fill tag C -> B is evicted, A and C hit, B misses (miss_cnt +1).
REQ-046 wr_s on cached 0xBEEF with wr_bsel=1, wr_data=0x12 -> hit_data=0x12EF; wr_s to an uncached addr -> no change.
REQ-047 fill 0x0000 and wr_s(bsel=0, data=0x55) in the same clk on the same addr -> hit_data=0x0055.
REQ-048 flush with counters at 0xFFFF (saturated) -> counters=0, busy=1 for 256 clks, all prior entries miss afterwards; rst_n pulsed at flush clk 100 -> busy stays 1 for 256 more clks.
